// File: rtl/moravec_scan_if.sv
// moravec_scan_if: job control and read-request bundle between the scan sequencer and its host.
interface moravec_scan_if #(parameter int ADDR_W = 7);
    logic start, abort, stall, rd_en, win_first, win_last, busy, done;
    logic [ADDR_W-1:0] rd_addr, win_row, win_col;
    modport master (
        output start, abort, stall,
        input rd_en, rd_addr, win_row, win_col, win_first, win_last, busy, done
    );
    modport slave (
        input start, abort, stall,
        output rd_en, rd_addr, win_row, win_col, win_first, win_last, busy, done
    );
endinterface

// File: rtl/moravec_scan_ctrl.sv
// moravec_scan_ctrl: walks every WxW window over an NxN image row-major, one read address per accepted beat.
module moravec_scan_ctrl #(
    parameter int N = 8,
    parameter int W = 3,
    parameter int ADDR_W = 7
) (
    input logic clk,
    input logic rst,
    moravec_scan_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    localparam logic [ADDR_W-1:0] N_A = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] W_MAX = ADDR_W'(W - 1);
    localparam logic [ADDR_W-1:0] C_MAX = ADDR_W'(N - W);
    state_t state, state_n;
    logic [ADDR_W-1:0] r, c, i, j, r_n, c_n, i_n, j_n;
    logic j_end, win_end, c_end;
    assign j_end = j == W_MAX;
    assign win_end = j_end && i == W_MAX;
    assign c_end = c == C_MAX;
    always_comb begin
        state_n = state;
        r_n = r;
        c_n = c;
        i_n = i;
        j_n = j;
        case (state)
            IDLE: if (bus.start) begin
                state_n = ISSUE;
                r_n = '0;
                c_n = '0;
                i_n = '0;
                j_n = '0;
            end
            ISSUE: if (bus.abort) state_n = IDLE;
            else if (!bus.stall) begin
                if (win_end && c_end && r == C_MAX) state_n = DONE;
                else begin
                    j_n = j_end ? '0 : j + 1'b1;
                    i_n = win_end ? '0 : j_end ? i + 1'b1 : i;
                    c_n = win_end ? (c_end ? '0 : c + 1'b1) : c;
                    r_n = win_end && c_end ? r + 1'b1 : r;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // outputs are registered from the next-state counters so they line up with the beat they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            r <= '0;
            c <= '0;
            i <= '0;
            j <= '0;
            bus.rd_en <= 1'b0;
            bus.rd_addr <= '0;
            bus.win_row <= '0;
            bus.win_col <= '0;
            bus.win_first <= 1'b0;
            bus.win_last <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state <= state_n;
            r <= r_n;
            c <= c_n;
            i <= i_n;
            j <= j_n;
            bus.rd_en <= state_n == ISSUE;
            bus.rd_addr <= (r_n + i_n) * N_A + c_n + j_n;
            bus.win_row <= r_n;
            bus.win_col <= c_n;
            bus.win_first <= state_n == ISSUE && i_n == '0 && j_n == '0;
            bus.win_last <= state_n == ISSUE && i_n == W_MAX && j_n == W_MAX;
            bus.busy <= state_n != IDLE;
            bus.done <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_moravec_scan_ctrl.sv
// tb_moravec_scan_ctrl: randomized scoreboard bench for W=3, W=8 and W=1 sequencers on an 8x8 image.
module tb_moravec_scan_ctrl;
    localparam int N = 8;
    localparam int AW = 7;
    typedef struct packed {
        logic [AW-1:0] addr, row, col;
        logic first, last;
    } beat_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] start_s = '0, abort_s = '0, stall_s = '0;
    logic [2:0] rd_en_a, first_a, last_a, busy_a, done_a;
    logic [AW-1:0] addr_a [3], row_a [3], col_a [3];
    int n_checks = 0, n_fail = 0, cur = 0, done_cnt = 0;
    beat_t exp_q [$];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : u
        moravec_scan_if #(.ADDR_W(AW)) bus ();
        assign bus.start = start_s[g];
        assign bus.abort = abort_s[g];
        assign bus.stall = stall_s[g];
        moravec_scan_ctrl #(.N(N), .W(g == 0 ? 3 : g == 1 ? 8 : 1), .ADDR_W(AW)) dut (
            .clk(clk), .rst(rst), .bus(bus)
        );
        assign rd_en_a[g] = bus.rd_en;
        assign first_a[g] = bus.win_first;
        assign last_a[g] = bus.win_last;
        assign busy_a[g] = bus.busy;
        assign done_a[g] = bus.done;
        assign addr_a[g] = bus.rd_addr;
        assign row_a[g] = bus.win_row;
        assign col_a[g] = bus.win_col;
    end
    function automatic int w_of(input int g);
        return g == 0 ? 3 : g == 1 ? 8 : 1;
    endfunction
    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask
    // reference: every window origin row-major, every pixel inside it row-major
    task automatic build(input int w, input int limit);
        beat_t b;
        int k = 0;
        for (int r = 0; r <= N - w; r++)
            for (int c = 0; c <= N - w; c++)
                for (int i = 0; i < w; i++)
                    for (int j = 0; j < w; j++) begin
                        b = {AW'((r + i) * N + c + j), AW'(r), AW'(c), i == 0 && j == 0, i == w - 1 && j == w - 1};
                        if (limit == 0 || k < limit) exp_q.push_back(b);
                        k++;
                    end
    endtask
    beat_t got, exp_b;
    logic [23:0] hold_v;
    bit held = 0;
    always @(negedge clk) begin
        got = {addr_a[cur], row_a[cur], col_a[cur], first_a[cur], last_a[cur]};
        if (rst) held = 0;
        else begin
            if (held) check("stall_hold", int'({rd_en_a[cur], got}), int'(hold_v));
            held = rd_en_a[cur] && stall_s[cur];
            hold_v = {rd_en_a[cur], got};
            if (rd_en_a[cur] && !stall_s[cur]) begin
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else begin
                    exp_b = exp_q.pop_front();
                    n_checks++;
                    if (got != exp_b) begin
                        n_fail++;
                        $display("FAIL beat: got addr=%0d row=%0d col=%0d first=%0b last=%0b, expected addr=%0d row=%0d col=%0d first=%0b last=%0b",
                                 got.addr, got.row, got.col, got.first, got.last,
                                 exp_b.addr, exp_b.row, exp_b.col, exp_b.first, exp_b.last);
                    end
                end
            end
            if (busy_a[cur] && !rd_en_a[cur]) check("flags_outside_issue", int'({first_a[cur], last_a[cur]}), 0);
            if (done_a[cur]) done_cnt++;
        end
    end
    task automatic run(input int g, input int stall_pct, input int abort_at, input bit spam);
        int w, total, cyc, stalls, acc, d0;
        bit fin;
        w = w_of(g);
        cur = g;
        total = w * w * (N - w + 1) * (N - w + 1);
        build(w, abort_at);
        d0 = done_cnt;
        @(posedge clk);
        #1 start_s[g] = 1'b1;
        @(posedge clk);
        #1 start_s[g] = 1'b0;
        check("first_rd_en", rd_en_a[g], 1);
        check("first_busy", busy_a[g], 1);
        cyc = 0;
        stalls = 0;
        acc = 0;
        fin = 0;
        while (!fin && cyc < 2000) begin
            if (done_a[g]) begin
                fin = 1;
                start_s[g] = 1'b0;
            end else begin
                stall_s[g] = $urandom_range(99) < stall_pct;
                if (spam) start_s[g] = 1'($urandom_range(1));
                if (rd_en_a[g]) begin
                    if (stall_s[g]) stalls++;
                    else begin
                        acc++;
                        if (acc == abort_at) abort_s[g] = 1'b1;
                    end
                end
                @(posedge clk);
                #1 abort_s[g] = 1'b0;
                cyc++;
                if (abort_at > 0 && acc == abort_at) fin = 1;
            end
        end
        stall_s[g] = 1'b0;
        start_s[g] = 1'b0;
        check("scan_timeout", int'(cyc >= 2000), 0);
        if (abort_at > 0) begin
            check("abort_rd_en", rd_en_a[g], 0);
            check("abort_busy", busy_a[g], 0);
            repeat (3) @(posedge clk);
            #1 check("abort_no_done", done_cnt, d0);
        end else begin
            check("done_high", done_a[g], 1);
            check("done_busy", busy_a[g], 1);
            check("done_rd_en", rd_en_a[g], 0);
            check("beat_count", acc, total);
            check("scan_cycles", cyc + 1, total + 1 + stalls);
            @(posedge clk);
            #1 check("idle_busy", busy_a[g], 0);
            check("done_one_cycle", done_a[g], 0);
            check("done_count", done_cnt, d0 + 1);
        end
        check("beats_left", exp_q.size(), 0);
    endtask
    task automatic reset_mid(input int g);
        int d0;
        cur = g;
        build(w_of(g), 0);
        d0 = done_cnt;
        @(posedge clk);
        #1 start_s[g] = 1'b1;
        @(posedge clk);
        #1 start_s[g] = 1'b0;
        repeat (50) @(posedge clk);
        #3 rst = 1'b1;
        #1 check("rst_async_outputs", int'({rd_en_a[g], addr_a[g], row_a[g], col_a[g], first_a[g], last_a[g], busy_a[g], done_a[g]}), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_no_done", done_cnt, d0);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++)
            check("reset_outputs", int'({rd_en_a[g], addr_a[g], row_a[g], col_a[g], first_a[g], last_a[g], busy_a[g], done_a[g]}), 0);
        rst = 1'b0;
        run(0, 0, 0, 0);
        run(0, 50, 0, 0);
        run(0, 0, 40, 0);
        run(0, 0, 0, 0);
        run(0, 30, 0, 1);
        reset_mid(0);
        run(0, 0, 0, 0);
        run(1, 0, 0, 0);
        run(1, 40, 0, 1);
        run(2, 0, 0, 0);
        run(2, 50, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
